// File: rtl/window_filter3x3.sv
// window_filter3x3
// 3x3 neighbourhood filter for a greyscale video stream. Two line buffers
// and a 3x3 window feed a three-stage pipeline. Each output pixel is one of
// four results: the centre pixel, a 1-2-1 Gaussian blur, the Sobel edge
// magnitude, or a thresholded edge.
//
// Ports
//   CLK       pixel clock
//   RST       asynchronous active-high reset
//   VSync     frame sync; a rising edge starts a frame and latches Mode/Thresh
//   HSync     line sync, delayed only
//   VDE       active video, PixIn valid while high
//   PixIn     greyscale pixel
//   Mode      00 pass, 01 blur, 10 edge, 11 thresholded edge
//   Thresh    edge threshold used in mode 11
//   PixOut    filtered pixel, 3 CLK after the pixel that completes the window
//   DEOut     VDE delayed 3 CLK
//   HSyncOut  HSync delayed 3 CLK
//   VSyncOut  VSync delayed 3 CLK
//   BinOut    1 when mode 11 and edge magnitude >= Thresh
`timescale 1ns/1ps
module window_filter3x3 #(
   parameter int PIX_W    = 8,
   parameter int LINE_LEN = 640,
   parameter int COL_W    = 10
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             VSync,
   input  logic             HSync,
   input  logic             VDE,
   input  logic [PIX_W-1:0] PixIn,
   input  logic [1:0]       Mode,
   input  logic [PIX_W-1:0] Thresh,
   output logic [PIX_W-1:0] PixOut,
   output logic             DEOut,
   output logic             HSyncOut,
   output logic             VSyncOut,
   output logic             BinOut
);

   localparam int AW    = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
   localparam int ROW_W = 12;
   localparam int BW    = PIX_W + 2;   // one weighted 1-2-1 row/column sum
   localparam int SW    = PIX_W + 3;   // signed Sobel term width

   // ---------------- position counters and frame-latched controls ----------
   logic [COL_W-1:0] col_q, col_d;
   logic             col_ovf_q, col_ovf_d;   // pixels beyond LINE_LEN-1
   logic [ROW_W-1:0] row_q, row_d;
   logic             vde_prev_q, vs_prev_q;
   logic [1:0]       mode_q;
   logic [PIX_W-1:0] thresh_q;
   logic             vs_rise, vde_fall, cap_valid;
   logic [AW-1:0]    addr;

   assign vs_rise   = VSync & ~vs_prev_q;
   assign vde_fall  = vde_prev_q & ~VDE;
   assign addr      = col_q[AW-1:0];
   assign cap_valid = VDE & ~col_ovf_q & (row_q >= ROW_W'(2)) & (col_q >= COL_W'(2));

   always_comb begin
      col_d     = col_q;
      col_ovf_d = col_ovf_q;
      row_d     = row_q;
      if (vs_rise) begin
         col_d     = '0;
         col_ovf_d = 1'b0;
         row_d     = '0;
      end else if (vde_fall) begin
         col_d     = '0;
         col_ovf_d = 1'b0;
         if (row_q != {ROW_W{1'b1}})
            row_d = row_q + ROW_W'(1);
      end else if (VDE) begin
         // col holds at the last address; the flag marks the overflow region
         if (col_q == COL_W'(LINE_LEN - 1))
            col_ovf_d = 1'b1;
         else
            col_d = col_q + COL_W'(1);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         col_q      <= '0;
         col_ovf_q  <= 1'b0;
         row_q      <= '0;
         vde_prev_q <= 1'b0;
         vs_prev_q  <= 1'b0;
         mode_q     <= 2'b00;
         thresh_q   <= '0;
      end else begin
         col_q      <= col_d;
         col_ovf_q  <= col_ovf_d;
         row_q      <= row_d;
         vde_prev_q <= VDE;
         vs_prev_q  <= VSync;
         if (vs_rise) begin
            mode_q   <= Mode;
            thresh_q <= Thresh;
         end
      end
   end

   // ---------------- S1: line buffers (registered read) and window ---------
   logic [PIX_W-1:0] lb0_mem [LINE_LEN];
   logic [PIX_W-1:0] lb1_mem [LINE_LEN];
   logic [PIX_W-1:0] rd0_q, rd1_q, pix_q;
   logic             v1_q;

   // Read-before-write: the old LB1 entry moves down into LB0 while the
   // incoming pixel replaces it.
   always_ff @(posedge CLK) begin
      if (VDE) begin
         rd0_q <= lb0_mem[addr];
         rd1_q <= lb1_mem[addr];
         if (!col_ovf_q) begin
            lb0_mem[addr] <= lb1_mem[addr];
            lb1_mem[addr] <= PixIn;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pix_q <= '0;
         v1_q  <= 1'b0;
      end else begin
         v1_q <= cap_valid;
         if (VDE)
            pix_q <= PixIn;
      end
   end

   // Window p[row][col]: row 0 = oldest line, col 0 = oldest column. The
   // newest column is the RAM read registers plus the registered input.
   logic [PIX_W-1:0] newest [3];
   logic [PIX_W-1:0] p [3][3];
   logic [BW-1:0]    brow [3];

   assign newest[0] = rd0_q;
   assign newest[1] = rd1_q;
   assign newest[2] = pix_q;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_row
         logic [PIX_W-1:0] tap0_q, tap1_q;
         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               tap0_q <= '0;
               tap1_q <= '0;
            end else if (VDE) begin
               tap1_q <= newest[gi];
               tap0_q <= tap1_q;
            end
         end
         assign p[gi][0] = tap0_q;
         assign p[gi][1] = tap1_q;
         assign p[gi][2] = newest[gi];
         // 1-2-1 horizontal sum of each window row (blur and Sobel Gy)
         assign brow[gi] = BW'(p[gi][0]) + BW'({p[gi][1], 1'b0}) + BW'(p[gi][2]);
      end
   endgenerate

   // ---------------- S2: partial sums and absolute gradients ---------------
   logic [SW-1:0] col_l, col_r, gx_raw, gy_raw, gx_abs, gy_abs;

   assign col_l  = SW'(p[0][0]) + SW'({p[1][0], 1'b0}) + SW'(p[2][0]);
   assign col_r  = SW'(p[0][2]) + SW'({p[1][2], 1'b0}) + SW'(p[2][2]);
   assign gx_raw = col_r - col_l;
   assign gy_raw = SW'(brow[2]) - SW'(brow[0]);
   assign gx_abs = gx_raw[SW-1] ? (SW'(0) - gx_raw) : gx_raw;
   assign gy_abs = gy_raw[SW-1] ? (SW'(0) - gy_raw) : gy_raw;

   logic [BW-1:0]    brow_q [3];
   logic [SW-1:0]    gx_abs_q, gy_abs_q;
   logic [PIX_W-1:0] centre_q;
   logic             v2_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < 3; i++) brow_q[i] <= '0;
         gx_abs_q <= '0;
         gy_abs_q <= '0;
         centre_q <= '0;
         v2_q     <= 1'b0;
      end else begin
         for (int i = 0; i < 3; i++) brow_q[i] <= brow[i];
         gx_abs_q <= gx_abs;
         gy_abs_q <= gy_abs;
         centre_q <= p[1][1];
         v2_q     <= v1_q;
      end
   end

   // ---------------- S3: final sums, saturation and mode mux ---------------
   logic [PIX_W+3:0] acc;
   logic [SW-1:0]    mag;
   logic [PIX_W-1:0] blur, edge_sat, pix_d, pix_out_q;
   logic             hit, bin_d, bin_out_q;

   assign acc      = (PIX_W+4)'(brow_q[0]) + (PIX_W+4)'({brow_q[1], 1'b0}) + (PIX_W+4)'(brow_q[2]);
   assign blur     = PIX_W'(acc >> 4);
   assign mag      = gx_abs_q + gy_abs_q;
   assign edge_sat = (mag > SW'({PIX_W{1'b1}})) ? {PIX_W{1'b1}} : PIX_W'(mag);
   assign hit      = (mag >= SW'(thresh_q));

   always_comb begin
      pix_d = '0;
      bin_d = 1'b0;
      if (v2_q) begin
         case (mode_q)
            2'b00: pix_d = centre_q;
            2'b01: pix_d = blur;
            2'b10: pix_d = edge_sat;
            default: begin
               pix_d = hit ? {PIX_W{1'b1}} : '0;
               bin_d = hit;
            end
         endcase
      end
   end

   // Timing signals take the same three register stages as the pixel data.
   logic [2:0] tim1_q, tim2_q, tim3_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pix_out_q <= '0;
         bin_out_q <= 1'b0;
         tim1_q    <= '0;
         tim2_q    <= '0;
         tim3_q    <= '0;
      end else begin
         pix_out_q <= pix_d;
         bin_out_q <= bin_d;
         tim1_q    <= {VDE, HSync, VSync};
         tim2_q    <= tim1_q;
         tim3_q    <= tim2_q;
      end
   end

   assign PixOut   = pix_out_q;
   assign BinOut   = bin_out_q;
   assign DEOut    = tim3_q[2];
   assign HSyncOut = tim3_q[1];
   assign VSyncOut = tim3_q[0];

endmodule

// File: tb/tb_window_filter3x3.sv
// Directed bench for window_filter3x3 (PIX_W=8, LINE_LEN=8). Frames are
// driven from an input image table; a negedge monitor rebuilds the output
// image from DEOut segments, and each frame is compared against
// hand-derived expected values.
`timescale 1ns/1ps
module tb_window_filter3x3;
   localparam int W  = 8;
   localparam int LL = 8;
   localparam int CW = 10;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         vs = 1'b0, hs = 1'b0, vde = 1'b0;
   logic [W-1:0] pix = '0, thr = '0;
   logic [1:0]   mode = 2'b00;
   logic [W-1:0] pix_out;
   logic         de_out, hs_out, vs_out, bin_out;

   always #5 clk = ~clk;

   window_filter3x3 #(.PIX_W(W), .LINE_LEN(LL), .COL_W(CW)) dut (
      .CLK(clk), .RST(rst), .VSync(vs), .HSync(hs), .VDE(vde), .PixIn(pix),
      .Mode(mode), .Thresh(thr), .PixOut(pix_out), .DEOut(de_out),
      .HSyncOut(hs_out), .VSyncOut(vs_out), .BinOut(bin_out)
   );

   int vec_cnt = 0;
   int err_cnt = 0;
   int in_img  [0:15][0:15];
   int out_img [0:15][0:15];
   int bin_img [0:15][0:15];
   int orow = 0, ocol = 0;
   bit prev_de = 0, prev_vs = 0;
   bit chk_timing = 0;
   logic [2:0] h1 = '0, h2 = '0, h3 = '0;

   task automatic check_val(input string tag, input int got, input int exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Output monitor: rebuilds the output image and checks the 3-cycle delay.
   always @(negedge clk) begin
      if (rst) begin
         orow = 0; ocol = 0; prev_de = 0; prev_vs = 0;
      end else begin
         if (vs_out && !prev_vs) begin
            orow = 0; ocol = 0;
         end
         if (de_out) begin
            if (orow < 16 && ocol < 16) begin
               out_img[orow][ocol] = int'(pix_out);
               bin_img[orow][ocol] = int'(bin_out);
            end
            ocol++;
         end else if (prev_de) begin
            orow++; ocol = 0;
         end
         prev_de = de_out;
         prev_vs = vs_out;
      end
      if (chk_timing) begin
         check_val("timing_delay3", int'({de_out, hs_out, vs_out}), int'(h3));
         if (!de_out) check_val("idle_zero", int'({pix_out, bin_out}), 0);
      end
      h3 = h2; h2 = h1; h1 = {vde, hs, vs};
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // kind: 0 ramp 16r+c, 1 const 100, 2 impulse 255 at (3,3),
   //       3 step 0|255 at col 4, 4 step 0|40 at col 4
   task automatic fill(input int kind);
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++) begin
            case (kind)
               0: in_img[r][c] = r * 16 + c;
               1: in_img[r][c] = 100;
               2: in_img[r][c] = (r == 3 && c == 3) ? 255 : 0;
               3: in_img[r][c] = (c >= 4) ? 255 : 0;
               default: in_img[r][c] = (c >= 4) ? 40 : 0;
            endcase
         end
   endtask

   task automatic drive_frame(input bit do_vs, input int m, input int mid_mode,
                              input int t, input int rows, input int cols,
                              input int abort_at);
      int k = 0;
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++) begin
            out_img[r][c] = -1;
            bin_img[r][c] = -1;
         end
      if (do_vs) begin
         mode = 2'(m);
         thr  = W'(t);
         vs   = 1'b1;
         repeat (2) step();
         vs = 1'b0;
      end
      repeat (2) step();
      for (int r = 0; r < rows; r++) begin
         hs = 1'b1; step(); hs = 1'b0;
         repeat (2) step();
         for (int c = 0; c < cols; c++) begin
            if (k == abort_at) return;
            vde = 1'b1;
            pix = W'(in_img[r][c]);
            step();
            k++;
         end
         vde = 1'b0;
         pix = '0;
         if (r == 0 && mid_mode >= 0) mode = 2'(mid_mode);
      end
      repeat (8) step();
   endtask

   // Expected output kinds: 0 pass ramp, 1 blur const, 2 blur impulse,
   // 3/4 step edge (4 also sets BinOut), 5 all zero, 6 ramp edge (Gx 8 + Gy 128)
   task automatic compare_frame(input string tag, input int kind, input int rows, input int cols);
      for (int r = 0; r < rows; r++)
         for (int c = 0; c < cols; c++) begin
            int e, eb, dr, dc, w;
            bit valid;
            e = 0; eb = 0;
            valid = (r >= 2 && c >= 2 && c <= LL - 1);
            if (valid) begin
               case (kind)
                  0: e = (r - 1) * 16 + (c - 1);
                  1: e = 100;
                  2: begin
                     dr = (r > 4) ? r - 4 : 4 - r;
                     dc = (c > 4) ? c - 4 : 4 - c;
                     w  = (dr <= 1 && dc <= 1) ? (2 - dr) * (2 - dc) : 0;
                     e  = (w == 4) ? 63 : (w == 2) ? 31 : (w == 1) ? 15 : 0;
                  end
                  3, 4: e = (c == 4 || c == 5) ? 255 : 0;
                  5: e = 0;
                  default: e = 136;
               endcase
            end
            if (kind == 4 && e == 255) eb = 1;
            check_val($sformatf("%s_pix_r%0d_c%0d", tag, r, c), out_img[r][c], e);
            check_val($sformatf("%s_bin_r%0d_c%0d", tag, r, c), bin_img[r][c], eb);
         end
      $display("frame %s: %0dx%0d compared, %0d vectors so far", tag, rows, cols, vec_cnt);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_val("reset_pix", int'(pix_out), 0);
      check_val("reset_de", int'(de_out), 0);
      check_val("reset_bin", int'(bin_out), 0);
      rst = 1'b0;
      repeat (2) step();

      // passthrough ramp, plus exact 3-cycle timing delay
      fill(0);
      chk_timing = 1;
      drive_frame(1, 0, -1, 0, 6, 8, -1);
      chk_timing = 0;
      compare_frame("pass", 0, 6, 8);

      // blur
      fill(1);
      drive_frame(1, 1, -1, 0, 6, 8, -1);
      compare_frame("blur_const", 1, 6, 8);
      fill(2);
      drive_frame(1, 1, -1, 0, 7, 8, -1);
      compare_frame("blur_impulse", 2, 7, 8);

      // edge saturation and threshold
      fill(3);
      drive_frame(1, 2, -1, 0, 6, 8, -1);
      compare_frame("edge_sat", 3, 6, 8);
      fill(4);
      drive_frame(1, 3, -1, 160, 6, 8, -1);
      compare_frame("thresh160", 4, 6, 8);
      drive_frame(1, 3, -1, 161, 6, 8, -1);
      compare_frame("thresh161", 5, 6, 8);

      // mode change mid-frame stays passthrough until the next VSync rise,
      // then the edge frame uses 11-pixel lines to exercise the overflow
      fill(0);
      drive_frame(1, 0, 2, 0, 6, 8, -1);
      compare_frame("mode_hold", 0, 6, 8);
      drive_frame(1, 2, -1, 0, 6, 11, -1);
      compare_frame("mode_edge_ovf", 6, 6, 11);

      // asynchronous reset in the middle of row 3
      drive_frame(1, 0, -1, 0, 6, 8, 29);
      check_val("pre_rst_de", int'(de_out), 1);
      check_val("pre_rst_pix", int'(pix_out), 33);
      #2;
      rst = 1'b1;
      #1;
      check_val("async_rst_pix", int'(pix_out), 0);
      check_val("async_rst_de", int'(de_out), 0);
      check_val("async_rst_bin", int'(bin_out), 0);
      vde = 1'b0;
      pix = '0;
      repeat (2) step();
      rst = 1'b0;
      repeat (2) step();
      drive_frame(0, 0, -1, 0, 6, 8, -1);
      compare_frame("rst_restart", 0, 6, 8);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
